// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state and error-cause enumerations.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_RESP = 2'b10,
      S_DONE = 2'b11
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10
   } lsu_err_e;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory port of the LSU.
// slave = the LSU itself, master = the core/memory environment.
interface lsu_if #(
   parameter int WIDTH = 32
);
   logic             i_req_valid;
   logic             o_req_ready;
   logic             i_is_store;
   logic [2:0]       i_funct3;
   logic [WIDTH-1:0] i_alu_data;
   logic [WIDTH-1:0] i_st_data;
   logic             o_mem_valid;
   logic             i_mem_ready;
   logic             o_mem_we;
   logic [WIDTH-1:0] o_mem_addr;
   logic [WIDTH-1:0] o_mem_wdata;
   logic [3:0]       o_mem_bmask;
   logic             i_mem_rvalid;
   logic [WIDTH-1:0] i_mem_rdata;
   logic             o_done;
   logic [WIDTH-1:0] o_ld_data;
   logic             o_err;
   logic [1:0]       o_err_cause;
   logic             o_busy;

   modport slave (
      input  i_req_valid, i_is_store, i_funct3, i_alu_data, i_st_data,
             i_mem_ready, i_mem_rvalid, i_mem_rdata,
      output o_req_ready, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
             o_mem_bmask, o_done, o_ld_data, o_err, o_err_cause, o_busy
   );

   modport master (
      output i_req_valid, i_is_store, i_funct3, i_alu_data, i_st_data,
             i_mem_ready, i_mem_rvalid, i_mem_rdata,
      input  o_req_ready, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
             o_mem_bmask, o_done, o_ld_data, o_err, o_err_cause, o_busy
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: store lane steering, byte masks,
// access legality and load extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       st_off_i,
   input  logic [2:0]       st_f3_i,
   input  logic             st_is_store_i,
   input  logic [WIDTH-1:0] st_data_i,
   output logic [WIDTH-1:0] st_wdata_o,
   output logic [3:0]       st_bmask_o,
   output logic             legal_o,
   input  logic [1:0]       ld_off_i,
   input  logic [2:0]       ld_f3_i,
   input  logic [WIDTH-1:0] ld_rdata_i,
   output logic [WIDTH-1:0] ld_data_o
);

   logic [WIDTH-1:0] ld_shift_s;

   // Store lanes are replicated so the memory can pick any enabled byte.
   always_comb begin
      st_wdata_o = st_data_i;
      st_bmask_o = 4'b1111;
      if (st_is_store_i) begin
         case (st_f3_i[1:0])
            2'b00: begin
               st_wdata_o = {4{st_data_i[7:0]}};
               st_bmask_o = 4'b0001 << st_off_i;
            end
            2'b01: begin
               st_wdata_o = {2{st_data_i[15:0]}};
               st_bmask_o = 4'b0011 << {st_off_i[1], 1'b0};
            end
            default: begin
               st_wdata_o = st_data_i;
               st_bmask_o = 4'b1111;
            end
         endcase
      end else begin
         st_bmask_o = 4'b1111;
      end
   end

   // Unsigned variants exist only for loads.
   always_comb begin
      case (st_f3_i)
         F3_B:    legal_o = 1'b1;
         F3_H:    legal_o = ~st_off_i[0];
         F3_W:    legal_o = (st_off_i == 2'b00);
         F3_BU:   legal_o = ~st_is_store_i;
         F3_HU:   legal_o = ~st_is_store_i & ~st_off_i[0];
         default: legal_o = 1'b0;
      endcase
   end

   assign ld_shift_s = ld_rdata_i >> {ld_off_i, 3'b000};

   // Load extension selected by the captured funct3.
   always_comb begin
      case (ld_f3_i)
         F3_B:    ld_data_o = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
         F3_H:    ld_data_o = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
         F3_BU:   ld_data_o = {24'h000000, ld_shift_s[7:0]};
         F3_HU:   ld_data_o = {16'h0000, ld_shift_s[15:0]};
         default: ld_data_o = ld_shift_s;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: FSM, request registers and registered outputs.
// Optional watchdog on the memory handshake with `define LSU_TIMEOUT_EN.
module lsu
   import lsu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic  i_clk,
   input logic  i_rst_n,
   lsu_if.slave bus
);

   lsu_state_e       state_q, state_d;
   lsu_err_e         cause_q, cause_d;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;
   logic             store_q;
   logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, ld_data_q;
   logic [3:0]       mem_bmask_q;
   logic             mem_we_q;
   logic             req_ready_q, busy_q, mem_valid_q, done_q, err_q;
   logic [1:0]       err_cause_q;
   logic             accept_s, legal_s, capture_s, clear_ld_s, tmo_hit_s;
   logic [WIDTH-1:0] st_wdata_s, ld_ext_s;
   logic [3:0]       st_bmask_s;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .st_off_i      (bus.i_alu_data[1:0]),
      .st_f3_i       (bus.i_funct3),
      .st_is_store_i (bus.i_is_store),
      .st_data_i     (bus.i_st_data),
      .st_wdata_o    (st_wdata_s),
      .st_bmask_o    (st_bmask_s),
      .legal_o       (legal_s),
      .ld_off_i      (off_q),
      .ld_f3_i       (f3_q),
      .ld_rdata_i    (bus.i_mem_rdata),
      .ld_data_o     (ld_ext_s)
   );

`ifdef LSU_TIMEOUT_EN
   logic [15:0] tmo_q;

   // Watchdog: cleared on accept, counts every cycle spent waiting on memory.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tmo_q <= 16'd0;
      end else if (accept_s) begin
         tmo_q <= 16'd0;
      end else if (state_q == S_REQ || state_q == S_RESP) begin
         tmo_q <= tmo_q + 16'd1;
      end else begin
         tmo_q <= tmo_q;
      end
   end

   assign tmo_hit_s = ((tmo_q + 16'd1) == 16'(TIMEOUT_CYC));
`else
   logic unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT_CYC != 0);
   assign tmo_hit_s    = 1'b0;
`endif

   // Next-state logic; rvalid is looked at only in S_RESP.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      accept_s   = 1'b0;
      capture_s  = 1'b0;
      clear_ld_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_req_valid) begin
               accept_s = 1'b1;
               if (legal_s) begin
                  state_d    = S_REQ;
                  cause_d    = ERR_NONE;
                  clear_ld_s = bus.i_is_store;
               end else begin
                  state_d    = S_DONE;
                  cause_d    = ERR_MISALIGN;
                  clear_ld_s = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus.i_mem_ready) begin
               state_d = store_q ? S_DONE : S_RESP;
            end else if (tmo_hit_s) begin
               state_d    = S_DONE;
               cause_d    = ERR_TIMEOUT;
               clear_ld_s = 1'b1;
            end else begin
               state_d = S_REQ;
            end
         end
         S_RESP: begin
            if (bus.i_mem_rvalid) begin
               state_d   = S_DONE;
               capture_s = 1'b1;
            end else if (tmo_hit_s) begin
               state_d    = S_DONE;
               cause_d    = ERR_TIMEOUT;
               clear_ld_s = 1'b1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, request capture and outputs registered from the next state.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         cause_q     <= ERR_NONE;
         off_q       <= 2'b00;
         f3_q        <= 3'b000;
         store_q     <= 1'b0;
         mem_addr_q  <= {WIDTH{1'b0}};
         mem_wdata_q <= {WIDTH{1'b0}};
         mem_bmask_q <= 4'b0000;
         mem_we_q    <= 1'b0;
         ld_data_q   <= {WIDTH{1'b0}};
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         mem_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cause_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         req_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         mem_valid_q <= (state_d == S_REQ);
         done_q      <= (state_d == S_DONE);
         err_q       <= (state_d == S_DONE) && (cause_d != ERR_NONE);
         err_cause_q <= (state_d == S_DONE) ? cause_d : ERR_NONE;
         if (accept_s && legal_s) begin
            off_q       <= bus.i_alu_data[1:0];
            f3_q        <= bus.i_funct3;
            store_q     <= bus.i_is_store;
            mem_addr_q  <= {bus.i_alu_data[WIDTH-1:2], 2'b00};
            mem_we_q    <= bus.i_is_store;
            mem_wdata_q <= st_wdata_s;
            mem_bmask_q <= st_bmask_s;
         end
         if (capture_s) begin
            ld_data_q <= ld_ext_s;
         end else if (clear_ld_s) begin
            ld_data_q <= {WIDTH{1'b0}};
         end
      end
   end

   assign bus.o_req_ready = req_ready_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_mem_valid = mem_valid_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_addr  = mem_addr_q;
   assign bus.o_mem_wdata = mem_wdata_q;
   assign bus.o_mem_bmask = mem_bmask_q;
   assign bus.o_done      = done_q;
   assign bus.o_ld_data   = ld_data_q;
   assign bus.o_err       = err_q;
   assign bus.o_err_cause = err_cause_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: store lanes, load extension, illegal accesses,
// backpressure, mid-transaction reset and (with LSU_TIMEOUT_EN) the watchdog.
module tb_lsu;
   import lsu_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   always #5 clk = ~clk;

   lsu_if #(.WIDTH(32)) bus ();

`ifdef LSU_TIMEOUT_EN
   lsu #(.WIDTH(32), .TIMEOUT_CYC(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
`else
   lsu #(.WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
`endif

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one request in the current cycle; returns one cycle later.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      bus.i_req_valid = 1'b1;
      bus.i_is_store  = st;
      bus.i_funct3    = f3;
      bus.i_alu_data  = a;
      bus.i_st_data   = d;
      tick();
      bus.i_req_valid = 1'b0;
   endtask

   task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_wd,
                            input logic [3:0] exp_bm);
      bus.i_mem_ready = 1'b1;
      issue(1'b1, f3, a, d);
      check_eq({tag, "_valid"}, bus.o_mem_valid, 32'd1);
      check_eq({tag, "_we"}, bus.o_mem_we, 32'd1);
      check_eq({tag, "_addr"}, bus.o_mem_addr, {a[31:2], 2'b00});
      check_eq({tag, "_wdata"}, bus.o_mem_wdata, exp_wd);
      check_eq({tag, "_bmask"}, bus.o_mem_bmask, exp_bm);
      check_eq({tag, "_done_c1"}, bus.o_done, 32'd0);
      tick();
      check_eq({tag, "_done_c2"}, bus.o_done, 32'd1);
      check_eq({tag, "_err"}, bus.o_err, 32'd0);
      check_eq({tag, "_ld0"}, bus.o_ld_data, 32'd0);
      check_eq({tag, "_valid_c2"}, bus.o_mem_valid, 32'd0);
      tick();
   endtask

   // rvalid is already high (with wrong data) during the handshake cycle.
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
      bus.i_mem_ready = 1'b1;
      issue(1'b0, f3, a, 32'h0);
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = ~rd;
      check_eq({tag, "_valid"}, bus.o_mem_valid, 32'd1);
      check_eq({tag, "_we"}, bus.o_mem_we, 32'd0);
      check_eq({tag, "_addr"}, bus.o_mem_addr, {a[31:2], 2'b00});
      check_eq({tag, "_bmask"}, bus.o_mem_bmask, 32'hF);
      tick();
      bus.i_mem_rdata = rd;
      check_eq({tag, "_done_c2"}, bus.o_done, 32'd0);
      tick();
      bus.i_mem_rvalid = 1'b0;
      check_eq({tag, "_done_c3"}, bus.o_done, 32'd1);
      check_eq({tag, "_data"}, bus.o_ld_data, exp);
      check_eq({tag, "_err"}, bus.o_err, 32'd0);
      tick();
      check_eq({tag, "_hold"}, bus.o_ld_data, exp);
      check_eq({tag, "_done_c4"}, bus.o_done, 32'd0);
   endtask

   task automatic run_err(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
      bus.i_mem_ready = 1'b1;
      issue(st, f3, a, 32'h5555AAAA);
      check_eq({tag, "_done"}, bus.o_done, 32'd1);
      check_eq({tag, "_err"}, bus.o_err, 32'd1);
      check_eq({tag, "_cause"}, bus.o_err_cause, 32'd1);
      check_eq({tag, "_valid"}, bus.o_mem_valid, 32'd0);
      check_eq({tag, "_ld0"}, bus.o_ld_data, 32'd0);
      tick();
      check_eq({tag, "_valid_c2"}, bus.o_mem_valid, 32'd0);
      check_eq({tag, "_done_c2"}, bus.o_done, 32'd0);
      check_eq({tag, "_ready"}, bus.o_req_ready, 32'd1);
   endtask

   initial begin
      bus.i_req_valid  = 1'b0;
      bus.i_is_store   = 1'b0;
      bus.i_funct3     = 3'b000;
      bus.i_alu_data   = 32'h0;
      bus.i_st_data    = 32'h0;
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'h0;
      tick();
      tick();
      check_eq("rst_ready", bus.o_req_ready, 32'd1);
      check_eq("rst_busy", bus.o_busy, 32'd0);
      check_eq("rst_valid", bus.o_mem_valid, 32'd0);
      check_eq("rst_done", bus.o_done, 32'd0);
      check_eq("rst_err", {bus.o_err, bus.o_err_cause}, 32'd0);
      check_eq("rst_addr", bus.o_mem_addr, 32'd0);
      check_eq("rst_bmask", bus.o_mem_bmask, 32'd0);
      check_eq("rst_ld", bus.o_ld_data, 32'd0);
      rst_n = 1'b1;
      tick();

      run_store("sb3", F3_B, 32'h00001003, 32'hAABBCCDD, 32'hDDDDDDDD, 4'b1000);
      run_store("sb1", F3_B, 32'h00001001, 32'hAABBCCDD, 32'hDDDDDDDD, 4'b0010);
      run_store("sh2", F3_H, 32'h00001002, 32'h1234BEEF, 32'hBEEFBEEF, 4'b1100);
      run_store("sh0", F3_H, 32'h00001000, 32'h1234BEEF, 32'hBEEFBEEF, 4'b0011);

      run_load("lb", F3_B, 32'h00002001, 32'h12348056, 32'hFFFFFF80);
      run_load("lbu", F3_BU, 32'h00002001, 32'h12348056, 32'h00000080);
      run_load("lb3", F3_B, 32'h00002003, 32'h7F000000, 32'h0000007F);
      run_load("lh2", F3_H, 32'h00002002, 32'h80010000, 32'hFFFF8001);
      run_load("lhu2", F3_HU, 32'h00002002, 32'h80010000, 32'h00008001);
      run_load("lw", F3_W, 32'h00002004, 32'hCAFEF00D, 32'hCAFEF00D);

      run_err("lh_mis", 1'b0, F3_H, 32'h00003001);
      run_err("f3_011", 1'b0, 3'b011, 32'h00003000);
      run_err("lw_mis", 1'b0, F3_W, 32'h00003002);
      run_err("sw_mis", 1'b1, F3_W, 32'h00003001);
      run_err("st_f3u", 1'b1, F3_BU, 32'h00003000);

      // Backpressure: request must hold still while memory stalls.
      bus.i_mem_ready = 1'b0;
      issue(1'b1, F3_W, 32'h00000040, 32'h11223344);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", bus.o_mem_valid, 32'd1);
         check_eq("bp_addr", bus.o_mem_addr, 32'h00000040);
         check_eq("bp_wdata", bus.o_mem_wdata, 32'h11223344);
         check_eq("bp_bmask", bus.o_mem_bmask, 32'hF);
         check_eq("bp_done", bus.o_done, 32'd0);
         check_eq("bp_ready", bus.o_req_ready, 32'd0);
         if (i < 4) tick();
      end
      bus.i_mem_ready = 1'b1;
      tick();
      bus.i_mem_ready = 1'b0;
      check_eq("bp_done_after", bus.o_done, 32'd1);
      check_eq("bp_err", bus.o_err, 32'd0);
      tick();

      // Reset while waiting for read data; the late rvalid must be ignored.
      bus.i_mem_ready = 1'b1;
      issue(1'b0, F3_W, 32'h00000080, 32'h0);
      tick();
      check_eq("mr_busy_resp", bus.o_busy, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("mr_busy", bus.o_busy, 32'd0);
      check_eq("mr_valid", bus.o_mem_valid, 32'd0);
      check_eq("mr_ready", bus.o_req_ready, 32'd1);
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'hDEADBEEF;
      tick();
      bus.i_mem_rvalid = 1'b0;
      check_eq("mr_done", bus.o_done, 32'd0);
      check_eq("mr_ld", bus.o_ld_data, 32'd0);
      check_eq("mr_busy2", bus.o_busy, 32'd0);
      tick();

`ifdef LSU_TIMEOUT_EN
      // Memory never answers: watchdog ends the load after 8 cycles in S_REQ.
      bus.i_mem_ready = 1'b0;
      issue(1'b0, F3_W, 32'h00000100, 32'h0);
      for (int i = 0; i < 8; i++) begin
         check_eq("to_valid", bus.o_mem_valid, 32'd1);
         check_eq("to_done_early", bus.o_done, 32'd0);
         tick();
      end
      check_eq("to_done", bus.o_done, 32'd1);
      check_eq("to_err", bus.o_err, 32'd1);
      check_eq("to_cause", bus.o_err_cause, 32'd2);
      check_eq("to_valid_drop", bus.o_mem_valid, 32'd0);
      tick();
      check_eq("to_ready", bus.o_req_ready, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the RV32I single-cycle-to-multicycle core.
- Consumes the ALU result as the effective address and drives a valid/ready data-memory port.
- Performs store byte-lane steering and load extraction with sign/zero extension.
- Holds the core (o_busy) until each access completes, and flags misaligned or illegal accesses without touching memory.

Parameters:
- WIDTH, 32, data/address width; only 32 supported.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  1  core presents an access.
- o_req_ready  out  1  LSU can accept; high only in S_IDLE.
- i_is_store  in  1  1=store, 0=load.
- i_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_alu_data  in  WIDTH  effective address from ALU.
- i_st_data  in  WIDTH  rs2 store data.
- o_mem_valid  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts request.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  WIDTH  word address, {addr[31:2],2'b00}.
- o_mem_wdata  out  WIDTH  lane-replicated store data.
- o_mem_bmask  out  4  byte enables (all-ones for loads).
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  WIDTH  read word.
- o_done  out  1  one-cycle completion pulse.
- o_ld_data  out  WIDTH  extended load result; valid when o_done and load.
- o_err  out  1  asserted with o_done on error.
- o_err_cause  out  2  00 none, 01 misalign/illegal, 10 timeout.
- o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset:
  - i_rst_n=0 at a clock edge forces state to S_IDLE.
  - All outputs go to 0, except o_req_ready=1.
  - A reset mid-transaction abandons the access; the memory side is reset with the same signal.
- Accept: i_req_valid & o_req_ready registers address, data, funct3 and is_store.
- Legality:
  - H/HU requires addr[0]=0; W requires addr[1:0]=00.
  - funct3 011/110/111 is illegal, as is a store with funct3[2]=1.
  - An illegal or misaligned request goes S_IDLE -> S_DONE directly, with o_err=1 and cause=01; no memory request is issued.
- States:
  - S_IDLE -> S_REQ on a legal accept.
  - S_REQ drives o_mem_valid=1. On i_mem_ready it goes to S_DONE (store) or S_RESP (load).
  - S_RESP waits for i_mem_rvalid, captures the extracted data, then goes to S_DONE.
  - S_DONE pulses o_done for one cycle and returns to S_IDLE.
- Request stability: all o_mem_* outputs are held stable while o_mem_valid & !i_mem_ready.
- Read-data timing: i_mem_rvalid is ignored outside S_RESP, so rvalid in the same cycle as the request handshake is not sampled.
- Latency (accept cycle = 0, zero-wait memory):
  - Store: o_done at cycle 2.
  - Load: o_done at cycle 3.
  - Misaligned: o_done at cycle 1.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, bmask=0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, bmask=0011<<(2*addr[1]).
  - SW: wdata=d, bmask=1111.
- Load extract: shift rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
- o_ld_data persistence: held until the next load captures; reads 0 for stores and errors.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on accept and increments in S_REQ/S_RESP.
  - When the count reaches TIMEOUT_CYC, the FSM goes to S_DONE with o_err=1, cause=10, and o_mem_valid drops.
- Undefined: no counter; the FSM waits indefinitely, and cause 10 is never produced.

Decomposition:
- lsu_pkg contains:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_e {S_IDLE,S_REQ,S_RESP,S_DONE}.
  - Error cause enum lsu_err_e.
- Sub-module lsu_align (combinational):
  - Store lane/mask generation.
  - Load shift/extension.
  - Legality check.

Test Plan:
1. Store SB, addr=0x1003, st_data=0xAABBCCDD, mem_ready immediate -> mem_addr=0x1000, bmask=1000, wdata=0xDDDDDDDD; o_done at cycle 2, o_err=0.
2. Load LB, addr=0x2001, rdata=0x12348056, rvalid one cycle after the handshake -> o_ld_data=0xFFFFFF80; load LBU at the same address -> 0x00000080.
3. LH at addr=0x3001 -> no o_mem_valid ever; o_done with o_err=1, cause=01 at cycle 1; funct3=011 gives the same result.
4. SW, addr=0x40, i_mem_ready held low 5 cycles -> o_mem_valid/addr/wdata stable throughout; bmask=1111; o_done 1 cycle after ready.
5. LW in flight, i_rst_n=0 during S_RESP -> next cycle o_busy=0, o_mem_valid=0, o_req_ready=1; a late i_mem_rvalid is ignored.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYC=8, LW with i_mem_ready never asserted -> o_done with o_err=1, cause=10 after 8 cycles in S_REQ.
